// File: rtl/sgd_error.sv
// Dot-product error term e = (w.x >>> FRAC_SHIFT) - y, replicated per lane; SGD_ERR_SAT_EN selects saturating narrowing.
// Latency: err_valid rises on the edge after the last beat is accepted.
// Backpressure: in_ready low while a result is held; the result is held until err_ready.
module sgd_error #(
   parameter int INPUT_BITWIDTH = 8,
   parameter int BITWIDTH       = 16,
   parameter int SIZE           = 10,
   parameter int ACC_WIDTH      = 32,
   parameter int FRAC_SHIFT     = 8,
   parameter int MAX_CHUNKS     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [INPUT_BITWIDTH*SIZE-1:0] x,
   input  logic [BITWIDTH*SIZE-1:0]     w,
   input  logic [BITWIDTH-1:0]          y,
   output logic                         err_valid,
   input  logic                         err_ready,
   output logic [BITWIDTH*SIZE-1:0]     err,
   output logic                         chunk_ovf
);

   localparam int PW = INPUT_BITWIDTH + BITWIDTH;
   localparam int CW = $clog2(MAX_CHUNKS + 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t                      r_state;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic [CW-1:0]               r_cnt;
   logic [BITWIDTH-1:0]         r_err;
   logic                        r_ovf;

   logic signed [ACC_WIDTH-1:0] w_psum;
   logic signed [ACC_WIDTH-1:0] w_acc_sum;
   logic signed [ACC_WIDTH-1:0] w_shifted;
   logic signed [ACC_WIDTH-1:0] w_y_ext;
   logic signed [ACC_WIDTH-1:0] w_diff;
   logic signed [PW-1:0]        w_xe;
   logic signed [PW-1:0]        w_we;
   logic signed [PW-1:0]        w_prod;
   logic [BITWIDTH-1:0]         w_err_nxt;
   logic                        w_force;
   logic                        w_last;

   // Both operands widened to PW so the product is exact at full precision.
   always_comb begin
      w_psum = '0;
      w_xe   = '0;
      w_we   = '0;
      w_prod = '0;
      for (int i = 0; i < SIZE; i++) begin
         w_xe   = {{BITWIDTH{x[INPUT_BITWIDTH*i+INPUT_BITWIDTH-1]}},
                   x[INPUT_BITWIDTH*i +: INPUT_BITWIDTH]};
         w_we   = {{INPUT_BITWIDTH{w[BITWIDTH*i+BITWIDTH-1]}},
                   w[BITWIDTH*i +: BITWIDTH]};
         w_prod = w_xe * w_we;
         w_psum = w_psum + {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
      end
   end

   assign w_acc_sum = r_acc + w_psum;
   assign w_shifted = w_acc_sum >>> FRAC_SHIFT;
   assign w_y_ext   = {{(ACC_WIDTH-BITWIDTH){y[BITWIDTH-1]}}, y};
   assign w_diff    = w_shifted - w_y_ext;

`ifdef SGD_ERR_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

   always_comb begin
      w_err_nxt = w_diff[BITWIDTH-1:0];
      if (w_diff > SAT_MAX)
         w_err_nxt = SAT_MAX[BITWIDTH-1:0];
      else if (w_diff < SAT_MIN)
         w_err_nxt = SAT_MIN[BITWIDTH-1:0];
   end
`else
   logic w_unused_hi;
   assign w_unused_hi = ^w_diff[ACC_WIDTH-1:BITWIDTH];
   assign w_err_nxt   = w_diff[BITWIDTH-1:0];
`endif

   // A non-last beat that would fill the final chunk slot closes the vector.
   assign w_force = (r_cnt == CW'(MAX_CHUNKS - 1));
   assign w_last  = in_last || w_force;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (in_valid) begin
                  if (w_last) begin
                     r_err   <= w_err_nxt;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_state <= HOLD;
                     if (!in_last)
                        r_ovf <= 1'b1;
                  end else begin
                     r_acc <= w_acc_sum;
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (err_ready)
                  r_state <= ACCUM;
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign err_valid = (r_state == HOLD);
   assign err       = {SIZE{r_err}};
   assign chunk_ovf = r_ovf;

endmodule

// File: doc/sgd_error.md
# sgd_error

Upstream companion of the per-lane SGD weight-update stage. Streams a feature vector as SIZE-lane chunks of x and the current weights w, accumulates the dot product w·x, and on the last chunk subtracts the label y to form the scalar error term e = (w·x >>> FRAC_SHIFT) − y. It presents e replicated across SIZE lanes, so the update stage can consume it directly as its per-lane gradient input. Flow control is a valid/ready handshake on both sides.

## Interface
- INPUT_BITWIDTH, 8, signed width of each x lane
- BITWIDTH, 16, signed width of w lanes, label, and error output
- SIZE, 10, lanes per beat
- ACC_WIDTH, 32, signed accumulator width
- FRAC_SHIFT, 8, arithmetic right shift applied to the accumulated dot product before subtraction
- MAX_CHUNKS, 16, maximum beats per vector

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  block accepts a beat
- in_last  in  1  final chunk of the vector
- x  in  INPUT_BITWIDTH*SIZE  feature lanes, lane i at [INPUT_BITWIDTH*i +: INPUT_BITWIDTH]
- w  in  BITWIDTH*SIZE  weight lanes
- y  in  BITWIDTH  label; sampled only on the accepted in_last beat
- err_valid  out  1  error result valid
- err_ready  in  1  consumer accepts the result
- err  out  BITWIDTH*SIZE  error e replicated in every lane
- chunk_ovf  out  1  sticky flag: a vector exceeded MAX_CHUNKS; cleared only by reset

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM with acc=0, cnt=0, err=0, err_valid=0, chunk_ovf=0.
- ACCUM:
  - in_ready=1, err_valid=0.
  - On in_valid: compute psum = Σ signed(w_i)·signed(x_i), sign-extended to ACC_WIDTH.
  - Not last: acc ← acc+psum, cnt ← cnt+1.
  - Last: compute e from acc+psum, load err, set acc=0, cnt=0, go to HOLD.
- Forced termination: if an accepted non-last beat would make cnt reach MAX_CHUNKS, treat that beat as last, set chunk_ovf, and use y from that beat.
- HOLD:
  - in_ready=0, err_valid=1, err stable.
  - On err_ready, go to ACCUM; err keeps its value, err_valid drops.
- Arithmetic:
  - Products are full precision, INPUT_BITWIDTH+BITWIDTH bits.
  - The accumulator wraps modulo 2^ACC_WIDTH.
  - Shift is arithmetic; subtraction is done in ACC_WIDTH.
  - Narrowing to BITWIDTH is set by Configuration.
- A single-beat vector (in_last on the first beat) is legal.

## Timing
- Latency: err_valid rises on the edge after the last beat is accepted.
- Throughput: N beats yield one result per N+1 cycles minimum (HOLD lasts at least 1 cycle).
- err_valid stays high and err stays constant until err_ready is sampled high.
- in_ready is a pure function of state; no combinational path from err_ready to in_ready.
- in_valid while in_ready=0 is ignored; no data is captured.
- Asserting rst mid-vector immediately clears all state and outputs and discards the partial sum.

## Configuration
- SGD_ERR_SAT_EN defined: the ACC_WIDTH result saturates to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1] before loading err.
- SGD_ERR_SAT_EN undefined: the result is truncated to its low BITWIDTH bits (wrap).
- Everything else is identical in both builds.

## Test plan
- Reset: rst high with random inputs → in_ready=1, err_valid=0, err=0, chunk_ovf=0. Reset released → block accepts the first beat on the next edge.
- Single beat, FRAC_SHIFT=0, lanes 0/1 x=2/3 and w=5/−1, other lanes 0, y=4, in_last=1 → next cycle err_valid=1, every lane err=3 (10−3−4).
- Three-beat vector, each beat giving psum=256, FRAC_SHIFT=8, y=1, with err_ready held low 5 cycles → err=2 in every lane; err_valid held; in_ready=0 throughout. After err_ready → a new vector starts from acc=0.
- Overflow: feed MAX_CHUNKS=16 beats without in_last → the 16th beat terminates the vector, chunk_ovf=1 and stays set across later vectors.
- Saturation: psum=0x00100000 with FRAC_SHIFT=0, y=0.
  - With SGD_ERR_SAT_EN: err=0x7FFF.
  - Without: err=0x0000.
- Reset mid-vector: rst pulsed after 2 of 4 beats → next vector's result excludes the discarded partial sum.
